// File: rtl/io_mmio_ctrl_pkg.sv
// Shared address map and helpers for the MIPS150 memory-mapped I/O block.
package io_mmio_ctrl_pkg;

    // I/O register addresses (full 32-bit decode).
    localparam logic [31:0] IO_TX_CTRL = 32'h8000_0000;
    localparam logic [31:0] IO_RX_CTRL = 32'h8000_0004;
    localparam logic [31:0] IO_TX_DATA = 32'h8000_0008;
    localparam logic [31:0] IO_RX_DATA = 32'h8000_000C;
    localparam logic [31:0] IO_CYC_CNT = 32'h8000_0010;
    localparam logic [31:0] IO_INS_CNT = 32'h8000_0014;
    localparam logic [31:0] IO_CNT_CLR = 32'h8000_0018;

    // The I/O region is the upper half of the address space.
    function automatic logic is_io(input logic [31:0] addr);
        return addr[31];
    endfunction

endpackage

// File: rtl/io_mmio_ctrl_buf1.sv
// One-entry byte holding buffer. A push is taken when the buffer is empty or
// is being drained in the same cycle; otherwise it is dropped. The data
// register holds its value until the next accepted push.
module io_buf1 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic [7:0] data
);

    logic take;
    assign take = push && (!full || pop);

    // Occupancy flag and data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= 8'h00;
        end else if (take) begin
            full <= 1'b1;
            data <= push_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/io_mmio_ctrl.sv
// MMIO controller: address decode, UART TX/RX holding buffers, cycle and
// retired-instruction counters, and the registered read-data port.
//
// Handshakes: a byte moves across a valid/ready pair exactly in a cycle where
// both valid and ready are 1 at the rising edge; valid, once raised, stays
// high with stable data until that transfer happens.
module io_mmio_ctrl
    import io_mmio_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [3:0]  mem_byte_en,
    input  logic        stall,
    input  logic        inst_retire,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    logic             rd_go;
    logic             wr_go;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic [7:0]       rx_byte;
    logic             cnt_clr;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ins_cnt;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign io_sel = is_io(mem_addr);
    assign rd_go  = mem_re && io_sel && !stall;
    assign wr_go  = mem_we && io_sel && !stall;

    assign tx_push = wr_go && (mem_addr == IO_TX_DATA) && (mem_byte_en != 4'b0000);
    assign tx_pop  = tx_full && uart_din_ready;
    // RX only refills when empty, so a pop and a capture never coincide.
    assign rx_push = uart_dout_valid && !rx_full;
    assign rx_pop  = rd_go && (mem_addr == IO_RX_DATA) && rx_full;
    assign cnt_clr = wr_go && (mem_addr == IO_CNT_CLR);

    assign uart_din_valid  = tx_full;
    assign uart_dout_ready = !rx_full;
    assign unused_wdata    = ^mem_wdata[31:8];

    io_buf1 u_tx (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (mem_wdata[7:0]),
        .pop       (tx_pop),
        .full      (tx_full),
        .data      (uart_din)
    );

    io_buf1 u_rx (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (uart_dout),
        .pop       (rx_pop),
        .full      (rx_full),
        .data      (rx_byte)
    );

    // Free-running counters; a clear write takes priority over the increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (inst_retire) begin
                ins_cnt <= ins_cnt + 1'b1;
            end
        end
    end

    // Read-data select from pre-edge state; unmapped addresses read as zero.
    always_comb begin
        rd_mux = 32'h0;
        case (mem_addr)
            IO_TX_CTRL: rd_mux = {31'b0, !tx_full};
            IO_RX_CTRL: rd_mux = {31'b0, rx_full};
            IO_RX_DATA: rd_mux = rx_full ? {24'b0, rx_byte} : 32'h0;
            IO_CYC_CNT: rd_mux = 32'(cyc_cnt);
            IO_INS_CNT: rd_mux = 32'(ins_cnt);
            default:    rd_mux = 32'h0;
        endcase
    end

    // Read data is loaded on performed reads only and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= 32'h0;
        end else if (rd_go) begin
            io_rdata <= rd_mux;
        end
    end

endmodule
